// File: rtl/product_display.sv
`default_nettype none
// +----------------------------------------------------------------------------------------+
// | product_display: captures the multiplier product on a rising done, converts it to BCD   |
// | with a sequential double-dabble and scans it onto a 2-digit common-anode 7-seg display. |
// | Build option: PRODUCT_DISPLAY_BLINK_EN (blink while a new multiplication is pending).   |
// | Revision: 1.0                                                                           |
// +----------------------------------------------------------------------------------------+
module product_display #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] pp_i,
    input  logic       done_i,
    output logic       busy_o,
    output logic       valid_o,
    output logic [3:0] bcd_tens_o,
    output logic [3:0] bcd_ones_o,
    output logic [6:0] seg_o,
    output logic [1:0] an_o
);

    localparam int unsigned        REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0]   REF_LAST = REF_W'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             done_q;
    logic [5:0]       sh_q, sh_d;
    logic [3:0]       tw_q, tw_d;
    logic [3:0]       ow_q, ow_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [REF_W-1:0] ref_q, ref_d;
    logic             digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;

    logic             start_w;
    logic [3:0]       tw_adj_w;
    logic [3:0]       ow_adj_w;
    logic [13:0]      shift_w;
    logic             ref_wrap_w;
    logic             blink_off_w;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign start_w  = done_i & ~done_q & (state_q == S_IDLE);
    assign tw_adj_w = (tw_q >= 4'd5) ? tw_q + 4'd3 : tw_q;
    assign ow_adj_w = (ow_q >= 4'd5) ? ow_q + 4'd3 : ow_q;
    // One double-dabble step: adjusted {tens,ones,sh} shifted left by one.
    assign shift_w  = {tw_adj_w[2:0], ow_adj_w, sh_q, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        tw_d    = tw_q;
        ow_d    = ow_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    sh_d    = pp_i;
                    tw_d    = 4'd0;
                    ow_d    = 4'd0;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                tw_d  = shift_w[13:10];
                ow_d  = shift_w[9:6];
                sh_d  = shift_w[5:0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    tens_d  = shift_w[13:10];
                    ones_d  = shift_w[9:6];
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ref_wrap_w = (ref_q == REF_LAST);

    always_comb begin
        ref_d   = ref_wrap_w ? '0 : ref_q + REF_W'(1);
        digit_d = digit_q ^ ref_wrap_w;
        an_d    = 2'b11;
        seg_d   = 7'h7F;
        // digit_q=0 selects units, 1 selects tens; tens has leading-zero suppression.
        if (valid_q && !blink_off_w) begin
            if (!digit_q) begin
                an_d  = 2'b10;
                seg_d = seg_of(ones_q);
            end else if (tens_q != 4'd0) begin
                an_d  = 2'b01;
                seg_d = seg_of(tens_q);
            end
        end
    end

`ifdef PRODUCT_DISPLAY_BLINK_EN
    localparam int unsigned      BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [BLK_W-1:0] blk_q, blk_d;
    logic             phase_off_q, phase_off_d;

    always_comb begin
        blk_d       = (blk_q == BLK_LAST) ? '0 : blk_q + BLK_W'(1);
        phase_off_d = phase_off_q ^ (blk_q == BLK_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q       <= '0;
            phase_off_q <= 1'b0;
        end else begin
            blk_q       <= blk_d;
            phase_off_q <= phase_off_d;
        end
    end

    // Blink only while a new multiplication is pending over a held result.
    assign blink_off_w = phase_off_q & ~done_i & valid_q;
`else
    // Steady display; BLINK_DIV is referenced only so the parameter is not dangling.
    assign blink_off_w = 1'b0 & (BLINK_DIV == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            sh_q    <= 6'd0;
            tw_q    <= 4'd0;
            ow_q    <= 4'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            ref_q   <= '0;
            digit_q <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= 2'b11;
        end else begin
            done_q  <= done_i;
            sh_q    <= sh_d;
            tw_q    <= tw_d;
            ow_q    <= ow_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            ref_q   <= ref_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign bcd_tens_o = tens_q;
    assign bcd_ones_o = ones_q;
    assign seg_o      = seg_q;
    assign an_o       = an_q;

endmodule

`default_nettype wire

// File: tb/tb_product_display.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------------------+
// | tb_product_display: randomized scoreboard bench for product_display.                    |
// | Revision: 1.0                                                                           |
// +----------------------------------------------------------------------------------------+
module tb_product_display;

    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 8;
    localparam int CONV_CYCLES = 6;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] pp    = 6'd0;
    logic       done  = 1'b0;
    logic       busy;
    logic       valid;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg;
    logic [1:0] an;

    product_display #(
        .REFRESH_DIV(REFRESH_DIV),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pp_i      (pp),
        .done_i    (done),
        .busy_o    (busy),
        .valid_o   (valid),
        .bcd_tens_o(bcd_tens),
        .bcd_ones_o(bcd_ones),
        .seg_o     (seg),
        .an_o      (an)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: each completed conversion (busy falling) is scored against the queue.
    bit prev_busy = 1'b0;
    int busy_run  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
            busy_run  = 0;
        end else begin
            if (busy) busy_run++;
            if (busy && !prev_busy) n_starts++;
            if (prev_busy && !busy) begin
                int v;
                chk("conversion latency", busy_run, CONV_CYCLES);
                chk("valid after conversion", int'(valid), 1);
                chk("pending expectation", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    v = exp_q.pop_front();
                    chk("bcd_tens", int'(bcd_tens), v / 10);
                    chk("bcd_ones", int'(bcd_ones), v % 10);
                end
                busy_run = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic fire(input logic [5:0] v);
        pp   = v;
        done = 1'b1;
        exp_q.push_back(int'(v));
    endtask

    task automatic wait_drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 40) begin
            tick(1);
            i++;
        end
        if (exp_q.size() != 0) begin
            chk("drain timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_display(input int v, input int n);
        int t = v / 10;
        int o = v % 10;
        bit seen_u = 1'b0;
        bit seen_t = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            case (an)
                2'b10: begin seen_u = 1'b1; chk("units seg", int'(seg), int'(seg_tab[o])); end
                2'b01: begin seen_t = 1'b1; chk("tens seg", int'(seg), int'(seg_tab[t])); end
                2'b11: ;
                default: chk("an both enabled", int'(an), 3);
            endcase
        end
        chk("units shown", int'(seen_u), 1);
        chk("tens shown", int'(seen_t), int'(t != 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s0;
        int off;
        int run;
        int ntr;
        bit first;
        logic [1:0] last_an;
        logic [5:0] v;

        // Asynchronous reset, observed before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("reset seg", int'(seg), 7'h7F);
        chk("reset an", int'(an), 3);
        chk("reset valid", int'(valid), 0);
        chk("reset busy", int'(busy), 0);
        #20;
        @(negedge clk); #1;
        rst_n = 1'b1;
        tick(3);
        chk("idle bcd_tens", int'(bcd_tens), 0);
        chk("idle bcd_ones", int'(bcd_ones), 0);
        chk("idle an blank", int'(an), 3);

        fire(6'd49);
        wait_drain();
        tick(2);
        check_display(49, 12);

        done = 1'b0; tick(1);
        fire(6'd0);
        wait_drain();
        tick(2);
        check_display(0, 12);

        // done held high: one conversion only; scan period is REFRESH_DIV cycles.
        done = 1'b0; tick(1);
        s0 = n_starts;
        fire(6'd42);
        run = 0; ntr = 0; first = 1'b1; last_an = 2'b11;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (i == 20) begin
                last_an = an;
                run = 1;
            end else if (i > 20) begin
                if (an == last_an) run++;
                else begin
                    if (!first) chk("scan period", run, REFRESH_DIV);
                    first = 1'b0;
                    ntr++;
                    last_an = an;
                    run = 1;
                end
            end
        end
        chk("scan transitions seen", int'(ntr >= 15), 1);
        chk("single busy pulse", n_starts - s0, 1);
        wait_drain();

        // Result held while done low, then replaced only on the next update.
        done = 1'b0; tick(1);
        fire(6'd49);
        wait_drain();
        tick(2);
        done = 1'b0;
        tick(2);
        off = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (an == 2'b11) off++;
            else if (an == 2'b10) chk("held units seg", int'(seg), int'(seg_tab[9]));
            else if (an == 2'b01) chk("held tens seg", int'(seg), int'(seg_tab[4]));
        end
`ifdef PRODUCT_DISPLAY_BLINK_EN
        chk("blink off cycles", off, 8);
`else
        chk("steady display off cycles", off, 0);
`endif
        fire(6'd6);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (busy) begin
                if (an == 2'b10) chk("busy units seg", int'(seg), int'(seg_tab[9]));
                else if (an == 2'b01) chk("busy tens seg", int'(seg), int'(seg_tab[4]));
            end
        end
        wait_drain();
        tick(2);
        check_display(6, 12);

        // Random products; pp scrambled and done re-pulsed during conversion.
        for (int k = 0; k < 12; k++) begin
            done = 1'b0; tick(1);
            s0 = n_starts;
            v = 6'($urandom_range(63));
            fire(v);
            tick(1);
            for (int j = 0; j < 5; j++) begin
                pp = 6'($urandom);
                if (j == 1) done = 1'b0;
                if (j == 2) done = 1'b1;
                tick(1);
            end
            wait_drain();
            tick(2);
            chk("starts per request", n_starts - s0, 1);
            check_display(int'(v), 12);
        end

        // Reset in the third conversion cycle.
        done = 1'b0; tick(1);
        pp = 6'd35;
        done = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        chk("busy before reset", int'(busy), 1);
        rst_n = 1'b0;
        done  = 1'b0;
        #1;
        chk("mid-conv reset busy", int'(busy), 0);
        chk("mid-conv reset valid", int'(valid), 0);
        chk("mid-conv reset an", int'(an), 3);
        chk("mid-conv reset seg", int'(seg), 7'h7F);
        chk("mid-conv reset bcd", int'({bcd_tens, bcd_ones}), 0);
        tick(2);
        rst_n = 1'b1;
        tick(12);
        chk("post-reset valid", int'(valid), 0);
        chk("post-reset busy", int'(busy), 0);
        chk("post-reset bcd", int'({bcd_tens, bcd_ones}), 0);
        chk("post-reset an", int'(an), 3);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
